// File: rtl/prism_cfg_seq.sv
// Configuration sequencer: queues host (addr, data) words, quiesces PRISM under
// debug reset, streams the words into its debug port, then re-enables the FSM.
module prism_cfg_seq #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2,
  parameter int ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_push,
  output logic                     host_ready,
  input  logic [ADDR_W-1:0]        host_addr,
  input  logic [31:0]              host_wdata,
  input  logic                     host_start,
  input  logic                     host_abort,
  input  logic                     host_stop,
  input  logic                     err_clr,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     prism_debug_reset,
  output logic                     prism_fsm_enable,
  output logic                     prism_debug_wr,
  output logic [ADDR_W-1:0]        prism_debug_addr,
  output logic [31:0]              prism_debug_wdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_QUIESCE = 2'd1;
  localparam logic [1:0] S_LOAD    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  settle_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [31:0]       mem_data [DEPTH];

  logic push;
  logic pop;
  logic go;
  logic start_empty;

  assign host_ready  = (count != LVL_FULL) && (state != S_LOAD);
  assign level       = count;
  // An abort flushes the queue, so a push landing in the same cycle is dropped too.
  assign push        = host_push && host_ready && !host_abort;
  assign pop         = (state == S_LOAD) && (count != '0) && !host_abort;
  assign go          = (state == S_IDLE) && host_start && !host_abort && (count != '0);
  assign start_empty = (state == S_IDLE) && host_start && !host_abort && (count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= host_addr;
      mem_data[wr_ptr] <= host_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      settle_cnt        <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      prism_debug_reset <= 1'b0;
      prism_fsm_enable  <= 1'b0;
      prism_debug_wr    <= 1'b0;
      prism_debug_addr  <= '0;
      prism_debug_wdata <= '0;
    end else begin
      done           <= 1'b0;
      prism_debug_wr <= 1'b0;

      if (err_clr) begin
        err <= 1'b0;
      end else if (start_empty) begin
        err <= 1'b1;
      end

      if (host_abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
          count  <= count + LVL_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
          count  <= count - LVL_ONE;
        end
      end

      if (host_abort) begin
        state             <= S_IDLE;
        busy              <= 1'b0;
        prism_debug_reset <= 1'b0;
        prism_fsm_enable  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (host_stop || go) begin
              prism_fsm_enable <= 1'b0;
            end
            if (go) begin
              busy              <= 1'b1;
              prism_debug_reset <= 1'b1;
              settle_cnt        <= CNT_INIT;
              // The first pop is issued on the last settle cycle so its write
              // lands exactly SETTLE cycles after the start.
              state             <= (SETTLE == 1) ? S_LOAD : S_QUIESCE;
            end
          end
          S_QUIESCE: begin
            settle_cnt <= settle_cnt - CNT_ONE;
            if (settle_cnt <= CNT_ONE) begin
              state <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (pop) begin
              prism_debug_wr    <= 1'b1;
              prism_debug_addr  <= mem_addr[rd_ptr];
              prism_debug_wdata <= mem_data[rd_ptr];
            end else begin
              prism_debug_reset <= 1'b0;
              state             <= S_RELEASE;
            end
          end
          S_RELEASE: begin
            state            <= S_IDLE;
            busy             <= 1'b0;
            prism_fsm_enable <= 1'b1;
            done             <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prism_cfg_seq.sv
// Directed bench for prism_cfg_seq: load timing, FIFO full/wrap, error flag,
// abort, host_stop and asynchronous reset in the middle of a sequence.
module tb_prism_cfg_seq;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;
  localparam int ADDR_W = 6;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   host_push;
  logic                   host_ready;
  logic [ADDR_W-1:0]      host_addr;
  logic [31:0]            host_wdata;
  logic                   host_start;
  logic                   host_abort;
  logic                   host_stop;
  logic                   err_clr;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [$clog2(DEPTH):0] level;
  logic                   prism_debug_reset;
  logic                   prism_fsm_enable;
  logic                   prism_debug_wr;
  logic [ADDR_W-1:0]      prism_debug_addr;
  logic [31:0]            prism_debug_wdata;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W-1:0] exp_addr [8];
  logic [31:0]       exp_data [8];

  always #5 clk = ~clk;

  prism_cfg_seq #(
    .DEPTH (DEPTH),
    .SETTLE(SETTLE),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .host_push        (host_push),
    .host_ready       (host_ready),
    .host_addr        (host_addr),
    .host_wdata       (host_wdata),
    .host_start       (host_start),
    .host_abort       (host_abort),
    .host_stop        (host_stop),
    .err_clr          (err_clr),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .level            (level),
    .prism_debug_reset(prism_debug_reset),
    .prism_fsm_enable (prism_fsm_enable),
    .prism_debug_wr   (prism_debug_wr),
    .prism_debug_addr (prism_debug_addr),
    .prism_debug_wdata(prism_debug_wdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    host_push  = 1'b1;
    host_addr  = a;
    host_wdata = d;
    tick();
    host_push  = 1'b0;
  endtask

  // Start at cycle t, then check every cycle t+1 .. t+SETTLE+n+2 against the
  // published timing. A push and a second start are attempted mid-load.
  task automatic run_load(input string id, input int n);
    logic rst_e, wr_e, busy_e, fin_e;
    int   lvl_e;
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    for (int k = 1; k <= SETTLE + n + 2; k++) begin
      rst_e  = (k <= SETTLE + n);
      wr_e   = (k >= SETTLE + 1) && (k <= SETTLE + n);
      busy_e = (k <= SETTLE + n + 1);
      fin_e  = (k == SETTLE + n + 2);
      lvl_e  = (k <= SETTLE) ? n : ((k <= SETTLE + n) ? n - (k - SETTLE) : 0);
      chk($sformatf("%s_k%0d_dbgrst", id, k), 64'(prism_debug_reset), 64'(rst_e));
      chk($sformatf("%s_k%0d_wr", id, k), 64'(prism_debug_wr), 64'(wr_e));
      chk($sformatf("%s_k%0d_busy", id, k), 64'(busy), 64'(busy_e));
      chk($sformatf("%s_k%0d_done", id, k), 64'(done), 64'(fin_e));
      chk($sformatf("%s_k%0d_en", id, k), 64'(prism_fsm_enable), 64'(fin_e));
      chk($sformatf("%s_k%0d_level", id, k), 64'(level), 64'(lvl_e));
      if (wr_e) begin
        chk($sformatf("%s_k%0d_addr", id, k), 64'(prism_debug_addr), 64'(exp_addr[k-SETTLE-1]));
        chk($sformatf("%s_k%0d_data", id, k), 64'(prism_debug_wdata), 64'(exp_data[k-SETTLE-1]));
      end
      if (k == SETTLE + n + 1) begin
        chk($sformatf("%s_hold_addr", id), 64'(prism_debug_addr), 64'(exp_addr[n-1]));
      end
      if (k == SETTLE + 1) begin
        chk($sformatf("%s_ready_in_load", id), 64'(host_ready), 64'(0));
        host_push  = 1'b1;
        host_addr  = 6'h3F;
        host_wdata = 32'hDEADBEEF;
        host_start = 1'b1;
      end
      tick();
      host_push  = 1'b0;
      host_start = 1'b0;
    end
    chk($sformatf("%s_done_after", id), 64'(done), 64'(0));
    chk($sformatf("%s_en_after", id), 64'(prism_fsm_enable), 64'(1));
    chk($sformatf("%s_level_after", id), 64'(level), 64'(0));
    chk($sformatf("%s_busy_after", id), 64'(busy), 64'(0));
  endtask

  initial begin
    rst        = 1'b1;
    host_push  = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    host_start = 1'b0;
    host_abort = 1'b0;
    host_stop  = 1'b0;
    err_clr    = 1'b0;
    tick();
    tick();

    // reset state
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_ready", 64'(host_ready), 64'(1));
    chk("rst_dbgrst", 64'(prism_debug_reset), 64'(0));
    chk("rst_en", 64'(prism_fsm_enable), 64'(0));
    chk("rst_wr", 64'(prism_debug_wr), 64'(0));
    chk("rst_addr", 64'(prism_debug_addr), 64'(0));
    chk("rst_data", 64'(prism_debug_wdata), 64'(0));
    rst = 1'b0;
    tick();

    // basic three-word load
    exp_addr[0] = 6'h04; exp_data[0] = 32'h11111111;
    exp_addr[1] = 6'h08; exp_data[1] = 32'h22222222;
    exp_addr[2] = 6'h0C; exp_data[2] = 32'h33333333;
    for (int i = 0; i < 3; i++) push_word(exp_addr[i], exp_data[i]);
    chk("basic_level3", 64'(level), 64'(3));
    run_load("basic", 3);

    // host_stop in IDLE after a completed load
    host_stop = 1'b1;
    tick();
    host_stop = 1'b0;
    chk("stop_en", 64'(prism_fsm_enable), 64'(0));
    chk("stop_busy", 64'(busy), 64'(0));

    // fill to DEPTH, extra push dropped, 4-word load across the pointer wrap
    exp_addr[0] = 6'h10; exp_data[0] = 32'hA0A0A0A0;
    exp_addr[1] = 6'h11; exp_data[1] = 32'hA1A1A1A1;
    exp_addr[2] = 6'h12; exp_data[2] = 32'hA2A2A2A2;
    exp_addr[3] = 6'h13; exp_data[3] = 32'hA3A3A3A3;
    for (int i = 0; i < 4; i++) push_word(exp_addr[i], exp_data[i]);
    chk("full_level", 64'(level), 64'(4));
    chk("full_ready", 64'(host_ready), 64'(0));
    push_word(6'h2A, 32'h55555555);
    chk("full_drop_level", 64'(level), 64'(4));
    run_load("fill", 4);

    exp_addr[0] = 6'h20; exp_data[0] = 32'hB0000001;
    exp_addr[1] = 6'h21; exp_data[1] = 32'hB0000002;
    exp_addr[2] = 6'h22; exp_data[2] = 32'hB0000003;
    exp_addr[3] = 6'h23; exp_data[3] = 32'hB0000004;
    for (int i = 0; i < 4; i++) push_word(exp_addr[i], exp_data[i]);
    chk("wrap_level", 64'(level), 64'(4));
    run_load("wrap", 4);

    // start with an empty FIFO
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    chk("empty_err", 64'(err), 64'(1));
    chk("empty_busy", 64'(busy), 64'(0));
    chk("empty_wr", 64'(prism_debug_wr), 64'(0));
    tick();
    chk("empty_busy2", 64'(busy), 64'(0));
    chk("empty_err_sticky", 64'(err), 64'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("errclr_err", 64'(err), 64'(0));
    host_start = 1'b1;
    err_clr    = 1'b1;
    tick();
    host_start = 1'b0;
    err_clr    = 1'b0;
    chk("start_errclr_err", 64'(err), 64'(0));
    chk("start_errclr_busy", 64'(busy), 64'(0));
    host_start = 1'b1;
    host_push  = 1'b1;
    host_addr  = 6'h01;
    host_wdata = 32'h0000_0001;
    tick();
    host_start = 1'b0;
    host_push  = 1'b0;
    chk("start_push_err", 64'(err), 64'(1));
    chk("start_push_level", 64'(level), 64'(1));
    chk("start_push_busy", 64'(busy), 64'(0));

    // abort coincident with start in IDLE
    host_start = 1'b1;
    host_abort = 1'b1;
    err_clr    = 1'b1;
    tick();
    host_start = 1'b0;
    host_abort = 1'b0;
    err_clr    = 1'b0;
    chk("abort_start_busy", 64'(busy), 64'(0));
    chk("abort_start_level", 64'(level), 64'(0));
    chk("abort_start_dbgrst", 64'(prism_debug_reset), 64'(0));
    tick();
    chk("abort_start_busy2", 64'(busy), 64'(0));

    // abort during LOAD after the first of three writes
    exp_addr[0] = 6'h30; exp_data[0] = 32'hC0000000;
    exp_addr[1] = 6'h31; exp_data[1] = 32'hC0000001;
    exp_addr[2] = 6'h32; exp_data[2] = 32'hC0000002;
    for (int i = 0; i < 3; i++) push_word(exp_addr[i], exp_data[i]);
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    tick();
    tick();
    chk("abort_first_wr", 64'(prism_debug_wr), 64'(1));
    chk("abort_first_addr", 64'(prism_debug_addr), 64'(exp_addr[0]));
    host_abort = 1'b1;
    tick();
    host_abort = 1'b0;
    chk("abort_wr", 64'(prism_debug_wr), 64'(0));
    chk("abort_dbgrst", 64'(prism_debug_reset), 64'(0));
    chk("abort_en", 64'(prism_fsm_enable), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_level", 64'(level), 64'(0));
    chk("abort_ready", 64'(host_ready), 64'(1));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("abort_tail%0d_wr", i), 64'(prism_debug_wr), 64'(0));
      chk($sformatf("abort_tail%0d_done", i), 64'(done), 64'(0));
      chk($sformatf("abort_tail%0d_busy", i), 64'(busy), 64'(0));
    end

    // asynchronous reset during QUIESCE, then a fresh load
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    chk("pre_rst_err", 64'(err), 64'(1));
    push_word(6'h05, 32'h0BAD0001);
    push_word(6'h06, 32'h0BAD0002);
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    chk("quiesce_busy", 64'(busy), 64'(1));
    chk("quiesce_dbgrst", 64'(prism_debug_reset), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_dbgrst", 64'(prism_debug_reset), 64'(0));
    chk("arst_err", 64'(err), 64'(0));
    chk("arst_level", 64'(level), 64'(0));
    chk("arst_ready", 64'(host_ready), 64'(1));
    chk("arst_en", 64'(prism_fsm_enable), 64'(0));
    #2;
    rst = 1'b0;
    tick();
    chk("post_rst_busy", 64'(busy), 64'(0));
    chk("post_rst_level", 64'(level), 64'(0));
    exp_addr[0] = 6'h3A; exp_data[0] = 32'hD00D0001;
    exp_addr[1] = 6'h3B; exp_data[1] = 32'hD00D0002;
    for (int i = 0; i < 2; i++) push_word(exp_addr[i], exp_data[i]);
    run_load("post", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
